ber_counter: RTL

Bit-error-rate checker at the receive end of the PRBS9 → BPSK → raised-cosine chain, directly downstream of the FIR filter. It decimates the filter's sign-bit output at a switch-selected sampling phase and stores the transmitted PRBS9 bits in a reference delay line. It searches for the TX→RX latency and, once aligned, counts received bits and bit errors. The block drives the "BER = 0" indicator and exposes counters for debug.

---
 rtl/comm_pkg.sv | 14 +
 rtl/ber_ref_buffer.sv | 35 +++
 rtl/ber_counter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// Shared constants and state encoding for the PRBS9 / BPSK receive chain.
package comm_pkg;

    localparam int OS_DEF       = 4;    // samples per symbol
    localparam int PRBS_LEN_DEF = 511;  // PRBS9 period
    localparam int CNT_W_DEF    = 64;   // bit / error counter width
    localparam int IDX_W        = 9;    // delay index width (covers 0..511)

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } ber_state_e;

endpackage

// File: rtl/ber_ref_buffer.sv
// Reference delay line holding the last DEPTH transmitted bits.
// Entry 0 is the newest bit; the read port selects any entry by index.
module ber_ref_buffer
    import comm_pkg::*;
#(
    parameter int DEPTH = PRBS_LEN_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_i,
    input  logic             bit_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             bit_o
);

    logic [DEPTH-1:0] line_q;

    // Shift the newest bit in at position 0 on each symbol strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_q <= '0;
        end else if (shift_i) begin
            line_q <= {line_q[DEPTH-2:0], bit_i};
        end
    end

    // Read mux; an out-of-range index reads as 0.
    always_comb begin
        bit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx_i == IDX_W'(i)) bit_o = line_q[i];
        end
    end

endmodule

// File: rtl/ber_counter.sv
// BER checker: decimates the filter sign bit at a selectable phase,
// searches for the TX->RX symbol latency, then counts bits and errors.
module ber_counter
    import comm_pkg::*;
#(
    parameter int OS       = OS_DEF,
    parameter int PRBS_LEN = PRBS_LEN_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_tx_bit,
    input  logic             i_rx_sample,
    input  logic [1:0]       i_phase,
    output logic             o_locked,
    output logic             o_is_zero,
    output logic [IDX_W-1:0] o_delay,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam logic [1:0]       PC_LAST  = 2'(OS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PRBS_LEN - 1);

    // Phase counter and capture stage
    logic [1:0] pc_q, pc_d;
    logic       rx_bit_q;
    logic       cmp_vld_q;
    logic       tx_stb, rx_stb;

    // Search / lock state
    ber_state_e       state_q;
    logic [IDX_W-1:0] d_q;
    logic [IDX_W-1:0] delay_q;
    logic [IDX_W-1:0] best_q;
    logic [IDX_W-1:0] win_err_q;
    logic [IDX_W-1:0] win_cnt_q;
    logic [IDX_W-1:0] min_err_q;
    logic             win_done_q;

    // Counters
    logic [CNT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             is_zero_q;

    logic [IDX_W-1:0] ref_idx;
    logic             ref_bit;
    logic             err_bit;

    assign pc_d   = (pc_q == PC_LAST) ? 2'd0 : pc_q + 2'd1;
    assign tx_stb = i_enable && (pc_q == 2'd0);
    assign rx_stb = i_enable && (pc_q == i_phase);

    // While searching the candidate delay is probed; once locked, the chosen one.
    assign ref_idx = (state_q == LOCK) ? delay_q : d_q;
    assign err_bit = rx_bit_q ^ ref_bit;

    // Saturating counter increments.
    assign bit_d = (&bit_q) ? bit_q : bit_q + CNT_W'(1);
    assign err_d = (err_bit && !(&err_q)) ? err_q + CNT_W'(1) : err_q;

    ber_ref_buffer #(
        .DEPTH(PRBS_LEN)
    ) u_ref (
        .clock  (clock),
        .reset  (reset),
        .shift_i(tx_stb),
        .bit_i  (i_tx_bit),
        .idx_i  (ref_idx),
        .bit_o  (ref_bit)
    );

    // Phase counter and sample capture; the compare happens the next enabled clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q      <= 2'd0;
            rx_bit_q  <= 1'b0;
            cmp_vld_q <= 1'b0;
        end else if (i_enable) begin
            pc_q      <= pc_d;
            cmp_vld_q <= rx_stb;
            if (rx_stb) rx_bit_q <= i_rx_sample;
        end
    end

    // Search/lock state machine with window accounting and locked counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            d_q        <= '0;
            delay_q    <= '0;
            best_q     <= '0;
            win_err_q  <= '0;
            win_cnt_q  <= '0;
            min_err_q  <= '1;
            win_done_q <= 1'b0;
            bit_q      <= '0;
            err_q      <= '0;
        end else if (i_enable) begin
            win_done_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    // Accumulate one compared symbol into the current window.
                    if (cmp_vld_q) begin
                        win_err_q <= win_err_q + {{(IDX_W-1){1'b0}}, err_bit};
                        if (win_cnt_q == LAST_IDX) begin
                            win_cnt_q  <= '0;
                            win_done_q <= 1'b1;
                        end else begin
                            win_cnt_q <= win_cnt_q + 1'b1;
                        end
                    end
                    // Window verdict, one clock after its last accumulate
                    // (never coincides with a compare since OS >= 2).
                    if (win_done_q) begin
                        win_err_q <= '0;
                        if (win_err_q == '0) begin
                            state_q <= LOCK;
                            delay_q <= d_q;
                        end else begin
                            if (win_err_q < min_err_q) begin
                                min_err_q <= win_err_q;
                                best_q    <= d_q;
                            end
                            if (d_q == LAST_IDX) begin
                                state_q <= LOCK;
                                delay_q <= (win_err_q < min_err_q) ? d_q : best_q;
                            end else begin
                                d_q <= d_q + 1'b1;
                            end
                        end
                    end
                end
                LOCK: begin
                    if (cmp_vld_q) begin
                        bit_q <= bit_d;
                        err_q <= err_d;
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    // Zero-error indicator trails the counters by one clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_zero_q <= 1'b0;
        end else begin
            is_zero_q <= (state_q == LOCK) && (err_q == '0);
        end
    end

    assign o_locked    = (state_q == LOCK);
    assign o_is_zero   = is_zero_q;
    assign o_delay     = delay_q;
    assign o_bit_count = bit_q;
    assign o_err_count = err_q;

endmodule
